// File: rtl/uart_data_tx.sv
// -----------------------------------------------------------------------------
// uart_data_tx
//
// Multi-byte UART transmitter. A DATA_WIDTH-bit word is captured on a one-cycle
// send_en request and sent as DATA_WIDTH/8 consecutive 8N1 frames, with no idle
// gap between frames. The baud rate is selected by baud_set and held for the
// whole word.
//
// Parameters
//   DATA_WIDTH : word width in bits, a multiple of 8 (8..64)
//   MSB_FIRST  : 0 = data[7:0] sent first, 1 = data[DATA_WIDTH-1 -: 8] first
//   CLK_FREQ   : clock frequency in Hz, used to derive the baud divisors
//
// Ports
//   clk        : system clock, rising edge
//   nrst       : asynchronous reset, active HIGH despite the name
//   data       : word to send, sampled only when a request is accepted
//   send_en    : one-cycle transmit request
//   baud_set   : 0..7 -> 9600, 19200, 38400, 57600, 115200, 230400, 460800,
//                921600 baud
//   uart_tx    : serial line, idles high
//   tx_done    : one-cycle pulse when the last stop bit of the word ends
//   uart_state : busy, high from acceptance until word completion
// -----------------------------------------------------------------------------
module uart_data_tx #(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int CLK_FREQ   = 50000000
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  send_en,
  input  logic [2:0]            baud_set,
  output logic                  uart_tx,
  output logic                  tx_done,
  output logic                  uart_state
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  // Bit index within a frame: 0 = start, 1..8 = data bits, 9 = stop.
  localparam logic [3:0] BIT_LAST_DATA = 4'd8;
  localparam logic [3:0] BIT_STOP      = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Clock cycles per bit for each baud selection (truncating division).
  function automatic logic [31:0] baud_div(input logic [2:0] sel);
    logic [31:0] div;
    case (sel)
      3'd0:    div = 32'(CLK_FREQ / 9600);
      3'd1:    div = 32'(CLK_FREQ / 19200);
      3'd2:    div = 32'(CLK_FREQ / 38400);
      3'd3:    div = 32'(CLK_FREQ / 57600);
      3'd4:    div = 32'(CLK_FREQ / 115200);
      3'd5:    div = 32'(CLK_FREQ / 230400);
      3'd6:    div = 32'(CLK_FREQ / 460800);
      default: div = 32'(CLK_FREQ / 921600);
    endcase
    return div;
  endfunction

  // Byte currently on the wire; the word register is shifted after each frame
  // so the active byte always sits at the same end.
  function automatic logic [7:0] active_byte(input logic [DATA_WIDTH-1:0] w);
    logic [7:0] b;
    if (MSB_FIRST) b = w[DATA_WIDTH-1 -: 8];
    else           b = w[7:0];
    return b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] next_word(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] n;
    if (MSB_FIRST) n = w << 8;
    else           n = w >> 8;
    return n;
  endfunction

  state_t                state_q,    state_d;
  logic [31:0]           div_m1_q,   div_m1_d;
  logic [31:0]           baud_cnt_q, baud_cnt_d;
  logic [3:0]            bit_cnt_q,  bit_cnt_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] word_q,     word_d;
  logic                  tx_q,       tx_d;
  logic                  done_q,     done_d;

  logic [7:0]            cur_byte;
  logic                  bit_end;

  assign cur_byte = active_byte(word_q);
  assign bit_end  = (baud_cnt_q == div_m1_q);

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q    <= IDLE;
      div_m1_q   <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_m1_q   <= div_m1_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_m1_d   = div_m1_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // A request in the same cycle as the tx_done pulse is dropped.
        if (send_en && !done_q) begin
          state_d    = SEND;
          word_d     = data;
          div_m1_d   = baud_div(baud_set) - 32'd1;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          tx_d       = 1'b0;
        end
      end

      SEND: begin
        if (!bit_end) begin
          baud_cnt_d = baud_cnt_q + 32'd1;
        end else begin
          baud_cnt_d = '0;
          if (bit_cnt_q == BIT_STOP) begin
            if (byte_cnt_q == LAST_BYTE) begin
              state_d = IDLE;
              done_d  = 1'b1;
              tx_d    = 1'b1;
            end else begin
              // Next start bit follows the stop bit with no gap.
              byte_cnt_d = byte_cnt_q + BCW'(1);
              bit_cnt_d  = '0;
              word_d     = next_word(word_q);
              tx_d       = 1'b0;
            end
          end else begin
            // Ending bit k drives the line value for bit k+1: data bit k after
            // the start or data bits 0..7, then the stop bit.
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == BIT_LAST_DATA) tx_d = 1'b1;
            else                            tx_d = cur_byte[bit_cnt_q[2:0]];
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign uart_tx    = tx_q;
  assign tx_done    = done_q;
  assign uart_state = (state_q == SEND);

endmodule

// File: tb/tb_uart_data_tx.sv
`timescale 1ns/1ps
module tb_uart_data_tx;

  logic        clk;
  logic        nrst;
  logic [31:0] data;
  logic [2:0]  baud_set;
  logic        send_en0, send_en1;
  logic        tx0, tx1, done0, done1, st0, st1;

  logic [1:0]  tx_bus, done_bus, st_bus;
  assign tx_bus   = {tx1, tx0};
  assign done_bus = {done1, done0};
  assign st_bus   = {st1, st0};

  uart_data_tx #(.DATA_WIDTH(32), .MSB_FIRST(1'b0), .CLK_FREQ(50000000)) dut (
    .clk(clk), .nrst(nrst), .data(data), .send_en(send_en0), .baud_set(baud_set),
    .uart_tx(tx0), .tx_done(done0), .uart_state(st0)
  );

  uart_data_tx #(.DATA_WIDTH(32), .MSB_FIRST(1'b1), .CLK_FREQ(50000000)) dut_m (
    .clk(clk), .nrst(nrst), .data(data), .send_en(send_en1), .baud_set(baud_set),
    .uart_tx(tx1), .tx_done(done1), .uart_state(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          dur_q[$];
  int          cur_div = 434;
  int          cyc = 0;
  int          done_cnt = 0;

  int          rx_st[2];
  int          rx_cnt[2];
  int          rx_k[2];
  logic [7:0]  rx_byte[2];
  int          w_start[2];
  logic        st_prev[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or not seen (t=%0t)", name, $time);
  endtask

  // Monitor: serial receiver and word-completion checker for both DUTs.
  initial begin
    for (int c = 0; c < 2; c++) begin
      rx_st[c] = 0; rx_cnt[c] = 0; rx_k[c] = 0; rx_byte[c] = '0;
      w_start[c] = 0; st_prev[c] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int ch = 0; ch < 2; ch++) begin
        if (nrst) begin
          rx_st[ch]   = 0;
          st_prev[ch] = 1'b0;
        end else begin
          // Receiver: sample every bit at its midpoint.
          if (rx_st[ch] == 0) begin
            if (tx_bus[ch] == 1'b0) begin
              rx_st[ch] = 1; rx_cnt[ch] = 0; rx_k[ch] = 0;
            end
          end else begin
            rx_cnt[ch]++;
            if (rx_cnt[ch] == rx_k[ch] * cur_div + cur_div / 2) begin
              if (rx_k[ch] == 0) begin
                chk("start_bit", 64'(tx_bus[ch]), 64'd0);
              end else if (rx_k[ch] <= 8) begin
                rx_byte[ch][rx_k[ch]-1] = tx_bus[ch];
              end else begin
                chk("stop_bit", 64'(tx_bus[ch]), 64'd1);
                if (exp_q.size() == 0) fail("unexpected_byte");
                else chk("rx_byte", 64'(rx_byte[ch]), 64'(exp_q.pop_front()));
                rx_st[ch] = 0;
              end
              rx_k[ch]++;
            end
          end
          // Word timing and busy flag.
          if (st_bus[ch] && !st_prev[ch]) w_start[ch] = cyc;
          if (st_prev[ch] && !st_bus[ch] && !done_bus[ch]) fail("busy_dropped_early");
          if (done_bus[ch]) begin
            done_cnt++;
            if (dur_q.size() == 0) fail("unexpected_tx_done");
            else chk("word_cycles", 64'(cyc - w_start[ch]), 64'(dur_q.pop_front()));
            chk("busy_clear_at_done", 64'(st_bus[ch]), 64'd0);
          end
          st_prev[ch] = st_bus[ch];
        end
      end
    end
  end

  // Call right after a rising edge; request is sampled on the next edge.
  task automatic send(input int ch, input logic [31:0] w, input logic [2:0] b,
                      input int div, input bit msb);
    #1;
    data     = w;
    baud_set = b;
    cur_div  = div;
    if (ch == 0) send_en0 = 1'b1; else send_en1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (msb) exp_q.push_back(w[31-8*i -: 8]);
      else     exp_q.push_back(w[8*i +: 8]);
    end
    dur_q.push_back(40 * div);
    @(posedge clk);
    #1;
    send_en0 = 1'b0;
    send_en1 = 1'b0;
    data     = 32'hDEADBEEF;
    baud_set = 3'd0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == start) fail("tx_done_timeout");
  endtask

  initial begin
    nrst = 1'b1; data = '0; baud_set = 3'd0; send_en0 = 1'b0; send_en1 = 1'b0;

    // Reset state
    repeat (10) @(posedge clk);
    #1;
    chk("rst_tx0", 64'(tx0), 64'd1);
    chk("rst_done0", 64'(done0), 64'd0);
    chk("rst_state0", 64'(st0), 64'd0);
    chk("rst_tx1", 64'(tx1), 64'd1);
    chk("rst_done1", 64'(done1), 64'd0);
    chk("rst_state1", 64'(st1), 64'd0);
    nrst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_tx0", 64'(tx0), 64'd1);
    chk("idle_state0", 64'(st0), 64'd0);

    // LSB-first word at 115200
    @(posedge clk);
    send(0, 32'h01234567, 3'd4, 434, 1'b0);
    repeat (5000) @(posedge clk);
    #1;
    chk("busy_mid_word", 64'(st0), 64'd1);
    wait_done(20000);

    // Back-to-back requests on the cycle after tx_done
    send(0, 32'h12345678, 3'd4, 434, 1'b0);
    wait_done(20000);
    send(0, 32'h23456789, 3'd4, 434, 1'b0);

    // Request while busy must be ignored
    repeat (8000) @(posedge clk);
    #1;
    data = 32'hFFFFFFFF; baud_set = 3'd7; send_en0 = 1'b1;
    @(posedge clk);
    #1;
    send_en0 = 1'b0; baud_set = 3'd0;
    wait_done(20000);
    repeat (1000) @(posedge clk);
    #1;
    chk("idle_after_ignore_tx", 64'(tx0), 64'd1);
    chk("idle_after_ignore_state", 64'(st0), 64'd0);

    // Reset during the second byte
    @(posedge clk);
    send(0, 32'hCAFEF00D, 3'd4, 434, 1'b0);
    repeat (6510) @(posedge clk);
    #2;
    nrst = 1'b1;
    #1;
    chk("abort_tx", 64'(tx0), 64'd1);
    chk("abort_state", 64'(st0), 64'd0);
    chk("abort_done", 64'(done0), 64'd0);
    exp_q.delete();
    dur_q.delete();
    repeat (5) @(posedge clk);
    #1;
    nrst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("no_done_after_abort", 64'(done_cnt), 64'd3);
    @(posedge clk);
    send(0, 32'h5A3C0FF0, 3'd5, 217, 1'b0);
    wait_done(12000);

    // MSB-first word at 921600
    @(posedge clk);
    send(1, 32'hA1B2C3D4, 3'd7, 54, 1'b1);
    wait_done(5000);
    repeat (100) @(posedge clk);
    #1;

    chk("exp_bytes_drained", 64'(exp_q.size()), 64'd0);
    chk("exp_words_drained", 64'(dur_q.size()), 64'd0);
    chk("total_tx_done", 64'(done_cnt), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
